// File: rtl/io_pkg.sv
// io_pkg: shared address map, STATUS bit layout and UART serializer state for io_periph.
package io_pkg;
  localparam logic [15:0] IO_TXDATA = 16'h0000;
  localparam logic [15:0] IO_STATUS = 16'h0004;
  localparam logic [15:0] IO_TIMER  = 16'h0008;
  localparam logic [15:0] IO_CMP    = 16'h000C;
  localparam logic [15:0] IO_IRQ    = 16'h0010;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_CNT   = 8;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/io_periph_uart_tx_ser.sv
// uart_tx_ser: 8N1 LSB-first serializer, CLK_DIV clocks per bit, accepts a byte only when idle.
module uart_tx_ser import io_pkg::*; #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int CW = $clog2(CLK_DIV);
  uart_state_t state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shr_q, shr_d;
  logic tick;
  assign tick = baud_q == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) state_d = valid_i ? S_START : S_IDLE;
    else if (tick) state_d = state_q == S_START ? S_DATA :
                             state_q == S_STOP  ? S_IDLE :
                             bit_q == 3'd7      ? S_STOP : S_DATA;
  end
  // baud counter restarts at every state or bit boundary
  always_comb begin
    baud_d = (state_q == S_IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d  = state_q != S_DATA ? 3'd0 : bit_q + 3'(tick);
    shr_d  = (state_q == S_IDLE && valid_i) ? data_i : shr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      baud_q <= '0;
      bit_q  <= '0;
      shr_q  <= '0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      shr_q  <= shr_d;
    end
  always_comb begin
    ready_o = state_q == S_IDLE;
    tx_o    = state_q == S_START ? 1'b0 : state_q == S_DATA ? shr_q[bit_q] : 1'b1;
  end
endmodule

// File: rtl/io_periph.sv
// io_periph: IO-bus responder with a FIFO-fed UART transmitter, free-running timer/compare and irq.
// Timer, CMP, IRQ registers and irq exist only when IO_TIMER_EN is defined.
module io_periph import io_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 868,
  parameter int TIMER_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_r,
  input  logic        io_w,
  input  logic [15:0] io_addr,
  inout  wire  [31:0] io_data,
  output logic        uart_tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [13:0] wa;
  logic full, empty, push, pop, ser_rdy;
  logic [31:0] status, tmr_rd, rdata;
  logic unused_bits;
  assign unused_bits = ^{io_addr[1:0], io_data[31:8]};
  assign wa    = io_addr[15:2];
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign pop   = ser_rdy && !empty;
  // a push into a full FIFO is still accepted when the same edge pops
  assign push  = io_w && wa == IO_TXDATA[15:2] && (!full || pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (push != pop) cnt_q <= push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= io_data[7:0];
  uart_tx_ser #(.CLK_DIV(CLK_DIV)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .data_i  (mem_q[rp_q]),
    .valid_i (!empty),
    .ready_o (ser_rdy),
    .tx_o    (uart_tx)
  );
`ifdef IO_TIMER_EN
  logic [TIMER_W-1:0] tmr_q, tmr_d, cmp_q, cmp_d;
  logic pend_q, pend_d, sel_tm, sel_cmp, sel_irq;
  assign sel_tm  = wa == IO_TIMER[15:2];
  assign sel_cmp = wa == IO_CMP[15:2];
  assign sel_irq = wa == IO_IRQ[15:2];
  // a match sets pending even when the same edge carries a clear
  always_comb begin
    tmr_d  = (io_w && sel_tm) ? io_data[TIMER_W-1:0] : tmr_q + 1'b1;
    cmp_d  = (io_w && sel_cmp) ? io_data[TIMER_W-1:0] : cmp_q;
    pend_d = (tmr_q == cmp_q) || (pend_q && !(io_w && sel_irq && io_data[0]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tmr_q  <= '0;
      cmp_q  <= '1;
      pend_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      cmp_q  <= cmp_d;
      pend_q <= pend_d;
    end
  assign tmr_rd = sel_tm ? 32'(tmr_q) : sel_cmp ? 32'(cmp_q) : sel_irq ? {31'b0, pend_q} : 32'b0;
  assign irq    = pend_q;
`else
  assign tmr_rd = '0;
  assign irq    = 1'b0;
`endif
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = !ser_rdy;
    status[ST_CNT+:8] = 8'(cnt_q);
    rdata = wa == IO_STATUS[15:2] ? status : tmr_rd;
  end
  assign io_data = (io_r && !io_w) ? rdata : 'z;
endmodule

// File: tb/tb_io_periph.sv
// tb_io_periph: directed checks of io_periph register map, UART framing, FIFO limits and timer.
module tb_io_periph;
  import io_pkg::*;
  logic clk = 1'b0, rst = 1'b1, io_r = 1'b0, io_w = 1'b0, tb_drv = 1'b0;
  logic [15:0] io_addr = '0;
  logic [31:0] tb_data = '0, rv;
  wire [31:0] io_data;
  logic uart_tx, irq;
  int total = 0, bad = 0, n;
  logic [7:0] rxq[$];
  logic [7:0] rx_b;
  logic [7:0] exp_rx [19];
  logic [9:0] fr;
  assign io_data = tb_drv ? tb_data : 'z;
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (io_data[g]);
  end
  always #5 clk = ~clk;
  io_periph #(.FIFO_DEPTH(16), .CLK_DIV(4), .TIMER_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_r    (io_r),
    .io_w    (io_w),
    .io_addr (io_addr),
    .io_data (io_data),
    .uart_tx (uart_tx),
    .irq     (irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    io_addr = a;
    tb_data = d;
    tb_drv = 1'b1;
    io_w = 1'b1;
    @(negedge clk);
    io_w = 1'b0;
    tb_drv = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    io_addr = a;
    io_r = 1'b1;
    #1 d = io_data;
    io_r = 1'b0;
    #1;
  endtask
  // receiver: mid-bit sampling, one byte per frame
  initial forever begin
    @(negedge clk);
    if (!rst && uart_tx === 1'b0) begin
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        rx_b[i] = uart_tx;
        if (i < 7) repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      rxq.push_back(rx_b);
    end
  end
  initial begin
    exp_rx[0] = 8'h55;
    exp_rx[1] = 8'hA5;
    for (int i = 0; i < 16; i++) exp_rx[2+i] = 8'(i);
    exp_rx[18] = 8'h77;
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_irq", irq, 0);
    check("rst_rel", io_data, 32'hFFFF_FFFF);
    rd(IO_STATUS, rv); check("rst_status", rv, 32'h2);
    @(negedge clk);
    rst = 1'b0;
    rd(IO_STATUS, rv); check("status0", rv, 32'h2);
    rd(IO_TXDATA, rv); check("txdata_rd", rv, 0);
    rd(16'h0100, rv); check("unmapped_100", rv, 0);
    rd(16'h0014, rv); check("unmapped_14", rv, 0);
    io_addr = IO_STATUS;
    #1 check("released", io_data, 32'hFFFF_FFFF);
    io_r = 1'b1; io_w = 1'b1; tb_drv = 1'b1; tb_data = 32'h1234_5678;
    #1 check("rw_nodrive", io_data, 32'h1234_5678);
    @(negedge clk);
    io_r = 1'b0; io_w = 1'b0; tb_drv = 1'b0;
    rd(IO_STATUS, rv); check("status_ro", rv, 32'h2);
    // single frame, 0x55
    wr(IO_TXDATA, 32'h55);
    rd(IO_STATUS, rv); check("st_queued", rv, 32'h100);
    @(negedge clk);
    rd(IO_STATUS, rv); check("st_busy", rv, 32'h6);
    fr = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 40; k++) begin
      check("frame_bit", uart_tx, fr[k/4]);
      @(negedge clk);
    end
    rd(IO_STATUS, rv); check("st_after", rv, 32'h2);
    // overflow while the serializer is busy
    wr(IO_TXDATA, 32'hA5);
    for (int i = 0; i < 16; i++) wr(IO_TXDATA, 32'(i));
    rd(IO_STATUS, rv); check("st_full", rv, 32'h1005);
    wr(IO_TXDATA, 32'h10);
    rd(IO_STATUS, rv); check("st_drop", rv, 32'h1005);
    n = 0;
    do begin
      rd(IO_STATUS, rv);
      if (rv[ST_BUSY]) begin @(negedge clk); n++; end
    end while (rv[ST_BUSY] && n < 200);
    check("st_full_idle", rv, 32'h1001);
    wr(IO_TXDATA, 32'h77);
    rd(IO_STATUS, rv); check("st_push_pop_full", rv, 32'h1005);
    n = 0;
    do begin
      rd(IO_STATUS, rv);
      if (rv != 32'h2) begin @(negedge clk); n++; end
    end while (rv != 32'h2 && n < 3000);
    check("drain", rv, 32'h2);
    repeat (5) @(negedge clk);
    check("rx_count", rxq.size(), 19);
    for (int i = 0; i < 19 && i < rxq.size(); i++) check("rx_byte", rxq[i], exp_rx[i]);
`ifdef IO_TIMER_EN
    wr(IO_CMP, 32'h20);
    wr(IO_TIMER, 32'h10);
    rd(IO_TIMER, rv); check("tmr_load", rv, 32'h10);
    rd(IO_CMP, rv); check("cmp_rd", rv, 32'h20);
    repeat (16) @(negedge clk);
    check("irq_pre", irq, 0);
    rd(IO_TIMER, rv); check("tmr_eq", rv, 32'h20);
    @(negedge clk);
    check("irq_set", irq, 1);
    rd(IO_IRQ, rv); check("irq_rd", rv, 1);
    wr(IO_IRQ, 1);
    check("irq_clr", irq, 0);
    wr(IO_CMP, 32'h40);
    wr(IO_TIMER, 32'h3E);
    @(negedge clk);
    @(negedge clk);
    wr(IO_IRQ, 1);
    check("irq_prio", irq, 1);
    wr(IO_IRQ, 1);
    check("irq_clr2", irq, 0);
    rd(IO_TIMER, rv);
    wr(IO_CMP, rv);
    repeat (5) @(negedge clk);
    check("cmp_eq_now", irq, 0);
    wr(IO_TIMER, 32'hFFFF_FFFE);
    rd(IO_TIMER, rv); check("tmr_fe", rv, 32'hFFFF_FFFE);
    @(negedge clk);
    rd(IO_TIMER, rv); check("tmr_ff", rv, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(IO_TIMER, rv); check("tmr_wrap", rv, 32'h0);
`else
    wr(IO_TIMER, 32'h5);
    rd(IO_TIMER, rv); check("tmr_off", rv, 0);
    wr(IO_CMP, 32'h5);
    rd(IO_CMP, rv); check("cmp_off", rv, 0);
    rd(IO_IRQ, rv); check("irqreg_off", rv, 0);
    repeat (20) @(negedge clk);
    check("irq_off", irq, 0);
`endif
    // reset in the middle of a frame
    wr(IO_TXDATA, 32'hC3);
    wr(IO_TXDATA, 32'h3C);
    repeat (6) @(negedge clk);
    rd(IO_STATUS, rv); check("st_mid", rv, 32'h104);
    rst = 1'b1;
    #1 check("rst_mid_tx", uart_tx, 1);
    check("rst_mid_irq", irq, 0);
    rd(IO_STATUS, rv); check("rst_mid_st", rv, 32'h2);
    check("rst_mid_rel", io_data, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_tx", uart_tx, 1);
    rd(IO_STATUS, rv); check("post_rst_st", rv, 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_periph.md
Name: io_periph

Overview:
- IO-bus responder serving the load/store stage's IO port (io_r/io_w, 16-bit io_addr, 32-bit tri-state io_data).
- Contains a memory-mapped UART transmitter fed by a TX FIFO, a free-running timer with compare, and an interrupt-pending register.
- The initiator samples read data in the same cycle, so reads are combinational. Writes commit on the clock edge.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries (power of two, ≥2).
- CLK_DIV, 868, clk cycles per UART bit (≥2).
- TIMER_W, 32, timer/compare width (≤32; zero-extended on read).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- io_r  input  1  read strobe (already bubble-qualified by initiator).
- io_w  input  1  write strobe.
- io_addr  input  16  byte address; bits [1:0] ignored.
- io_data  inout  32  driven by block only when io_r && !io_w, else 'z.
- uart_tx  output  1  serial out, idle high.
- irq  output  1  level interrupt = timer_pending.

Behaviour:
- Reset is asynchronous:
  - FIFO empty, pointers 0.
  - Serializer IDLE, uart_tx=1.
  - timer=0, cmp={TIMER_W{1}}, timer_pending=0, irq=0.
  - io_data released ('z).
- Register map (io_addr[15:2]):
  - 0x0000 TXDATA: W pushes io_data[7:0]. R returns 0.
  - 0x0004 STATUS (R only):
    - bit0 = fifo_full
    - bit1 = fifo_empty
    - bit2 = ser_busy
    - [15:8] = fifo count
    - others 0.
  - 0x0008 TIMER: R returns current value. W loads io_data[TIMER_W-1:0].
  - 0x000C CMP: R/W.
  - 0x0010 IRQ: R bit0 = timer_pending. W with bit0=1 clears it.
  - Unmapped addresses: read 0, writes ignored.
- Reads:
  - Zero-latency combinational mux on io_addr.
  - TIMER read returns the pre-edge value.
  - io_r && io_w together is treated as a write only; io_data is not driven.
- Writes take effect at the posedge where io_w=1.
- FIFO:
  - Push when io_w to TXDATA and not full.
  - A push while full is dropped silently; contents and count are unchanged.
  - Pop when the serializer is IDLE and the FIFO is not empty.
  - Push and pop in the same cycle leaves the count unchanged. This is legal at count=FIFO_DEPTH, where the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.
- Serializer FSM (8N1, LSB first), states IDLE → START → DATA → STOP → IDLE:
  - IDLE: uart_tx=1. On pop, latch the byte and enter START.
  - START: uart_tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, each held CLK_DIV cycles. Bit counter 0..7.
  - STOP: uart_tx=1 for CLK_DIV cycles, then IDLE.
  - A new byte may pop on the first IDLE cycle after STOP, giving back-to-back frames of 10*CLK_DIV cycles plus 1 idle cycle.
  - The baud counter reloads at every state/bit boundary.
  - ser_busy = (state != IDLE).
- Timer:
  - Increments every cycle and wraps at 2^TIMER_W.
  - A TIMER write overrides the increment that cycle; the next cycle increments from the written value.
  - Match: when the timer value equals cmp, timer_pending is set on the next edge.
  - Set has priority over a same-cycle IRQ clear.
  - Writing CMP equal to the current timer value does not match until the next equality.
- irq is registered: irq == timer_pending.

Optional Feature:
- Macro IO_TIMER_EN.
  - Defined: timer, CMP, IRQ registers and irq behave as above.
  - Undefined: no timer logic. TIMER/CMP/IRQ read 0, writes are ignored, irq is tied 0. The UART is unaffected.

Decomposition:
- Shared package io_pkg holds:
  - Address constants IO_TXDATA, IO_STATUS, IO_TIMER, IO_CMP, IO_IRQ.
  - STATUS bit indices.
  - The serializer state enum uart_state_t.
- The io_periph top holds the register file, FIFO and timer.
- One sub-module, uart_tx_ser, takes byte, valid and CLK_DIV, and returns ready and tx.

Test Plan:
- Reset mid-frame: assert rst during the DATA state → uart_tx=1 immediately, STATUS reads 0x00000002, FIFO empty.
- Write 0x55 to 0x0000, CLK_DIV=4 → uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, STATUS bit2=1 during the frame.
- Push 17 bytes (0x00..0x10) with FIFO_DEPTH=16 while the serializer is busy on the first → count saturates at 16 with bit0=1, the overflow byte is dropped, and the serial output sequence omits it.
- io_r at 0x0004 with io_w=0 → io_data driven the same cycle. io_r=0 → io_data is 'z. Unmapped 0x0100 reads 0.
- (IO_TIMER_EN) Write CMP=0x20, TIMER=0x10 → irq rises 17 cycles later. Write 1 to 0x0010 → irq=0 next cycle. TIMER reads 0xFFFFFFFF then 0x0 across the wrap.
- IO_TIMER_EN undefined: write TIMER=5, read back → 0, irq stays 0.
